// File: rtl/apb_completer_regs.sv
`default_nettype none
// ============================================================================
// Module      : apb_completer_regs
// Description : APB completer terminating a bus with a bank of 32-bit
//               registers and a fixed number of wait states per access.
//               Register 0 is a read-only ID register.
// Optional    : APB_COMPLETER_PSLVERR_EN adds the pslverr output.
// Ports       : clk, rst_n        clock, async active-low reset
//               paddr/psel/penable/pwrite/pwdata   APB request inputs
//               prdata/pready    APB response (registered)
//               pslverr          error response (optional)
// Revision    : 1.0  initial release
// ============================================================================
module apb_completer_regs #(
  parameter int          NUM_REGS    = 16,
  parameter int          WAIT_CYCLES = 0,
  parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] paddr,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready
`ifdef APB_COMPLETER_PSLVERR_EN
  ,
  output logic        pslverr
`endif
);

  localparam int         c_IDX_W = $clog2(NUM_REGS);
  localparam logic [3:0] c_WAIT  = 4'(WAIT_CYCLES);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic                w_setup;
  logic                w_done;
  logic                w_abort;

  logic [31:0]         r_addr;
  logic                r_write;
  logic [31:0]         r_wdata;
  logic [3:0]          r_wcnt;
  logic                r_pready;
  logic [31:0]         r_prdata;
  logic [31:0]         r_regs [1:NUM_REGS-1];

  // Address/direction of the transfer in flight. In IDLE the bus inputs are
  // used directly so that a zero-wait read can load prdata at the setup edge.
  logic [31:0]         w_cur_addr;
  logic                w_cur_write;
  logic [c_IDX_W-1:0]  w_idx;
  logic                w_bad;
  logic [31:0]         w_rd_val;

  assign w_cur_addr  = (r_state == S_IDLE) ? paddr  : r_addr;
  assign w_cur_write = (r_state == S_IDLE) ? pwrite : r_write;
  assign w_idx       = w_cur_addr[2 +: c_IDX_W];
  assign w_bad       = (|w_cur_addr[31:c_IDX_W+2]) | (|w_cur_addr[1:0]);

  always_comb begin
    w_rd_val = 32'h0;
    if (!w_bad) begin
      if (w_idx == '0) begin
        w_rd_val = ID_VALUE;
      end else begin
        for (int i = 1; i < NUM_REGS; i++) begin
          if (w_idx == c_IDX_W'(i)) w_rd_val = r_regs[i];
        end
      end
    end
  end

`ifdef APB_COMPLETER_PSLVERR_EN
  logic r_pslverr;
  logic w_err;
  assign w_err   = w_bad | (w_cur_write & (w_idx == '0));
  assign pslverr = r_pslverr;
`endif

  // --------------------------------------------------------------------------
  // FSM next-state
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_setup      = 1'b0;
    w_done       = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      S_IDLE: begin
        // penable without a preceding setup phase is ignored
        if (psel && !penable) begin
          w_setup      = 1'b1;
          w_state_next = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (!psel) begin
          w_abort      = 1'b1;
          w_state_next = S_IDLE;
        end else if (penable && r_pready) begin
          w_done       = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // State, datapath and register bank
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_addr    <= 32'h0;
      r_write   <= 1'b0;
      r_wdata   <= 32'h0;
      r_wcnt    <= 4'h0;
      r_pready  <= 1'b0;
      r_prdata  <= 32'h0;
`ifdef APB_COMPLETER_PSLVERR_EN
      r_pslverr <= 1'b0;
`endif
      for (int i = 1; i < NUM_REGS; i++) r_regs[i] <= 32'h0;
    end else begin
      r_state <= w_state_next;

      if (w_setup) begin
        r_addr   <= paddr;
        r_write  <= pwrite;
        r_wdata  <= pwdata;
        r_wcnt   <= c_WAIT;
        r_pready <= (c_WAIT == 4'h0);
        if (c_WAIT == 4'h0) begin
          if (!w_cur_write) r_prdata <= w_rd_val;
`ifdef APB_COMPLETER_PSLVERR_EN
          r_pslverr <= w_err;
`endif
        end
      end else if (w_abort || w_done) begin
        r_pready <= 1'b0;
`ifdef APB_COMPLETER_PSLVERR_EN
        r_pslverr <= 1'b0;
`endif
      end else if (r_state == S_ACCESS && r_wcnt != 4'h0) begin
        // counter saturates at zero; pready rises on the 1 -> 0 step
        r_wcnt <= r_wcnt - 4'h1;
        if (r_wcnt == 4'h1) begin
          r_pready <= 1'b1;
          if (!w_cur_write) r_prdata <= w_rd_val;
`ifdef APB_COMPLETER_PSLVERR_EN
          r_pslverr <= w_err;
`endif
        end
      end

      // Writes commit only on the completion edge, from the latched request
      for (int i = 1; i < NUM_REGS; i++) begin
        if (w_done && r_write && !w_bad && (w_idx == c_IDX_W'(i))) begin
          r_regs[i] <= r_wdata;
        end
      end
    end
  end

  assign prdata = r_prdata;
  assign pready = r_pready;

endmodule
`default_nettype wire
